lab7_serial_sub: RTL and testbench

Bit-serial subtractor computing `d = a - b - bin` one bit per clock, LSB first, with a start/done handshake. It is the inverse-direction companion to the lab's combinational `a + b + cin` adder. Its result format mirrors the adder's extended-width sum: WIDTH difference bits plus a borrow/sign bit. It sits behind the lab's switch/button input stage and feeds the result display.

---
 rtl/lab7_pkg.sv | 22 ++
 rtl/lab7_full_sub.sv | 22 ++
 rtl/lab7_serial_sub.sv | 111 +++++++++++
 tb/tb_lab7_serial_sub.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lab7_pkg.sv
// ============================================================================
//  lab7_pkg : shared types and sizing helpers for the lab7 serial subtractor
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit-counter width for a given operand width: $clog2(WIDTH+1)
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab7_full_sub.sv
// ============================================================================
//  lab7_full_sub : 1-bit combinational full subtractor (x - y - bi)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab7_full_sub
  import lab7_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

`default_nettype wire

// File: rtl/lab7_serial_sub.sv
// ============================================================================
//  lab7_serial_sub : bit-serial d = a - b - bin, LSB first, start/done handshake
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab7_serial_sub
  import lab7_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     d_q, d_d;

  logic               diff_bit;
  logic               borrow_bit;
  logic [WIDTH-1:0]   res_shift;

  lab7_full_sub u_full_sub (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (diff_bit),
    .bo (borrow_bit)
  );

  // The last diff bit goes straight into d, so the shift register only
  // needs to hold the lower WIDTH-1 bits.
  assign res_shift = {diff_bit, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrow_bit;
        res_d = res_shift[WIDTH-1:1];
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          d_d     = {borrow_bit, diff_bit, res_q};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;

endmodule

`default_nettype wire

// File: tb/tb_lab7_serial_sub.sv
// ============================================================================
//  tb_lab7_serial_sub : directed and exhaustive checks of lab7_serial_sub
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lab7_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [4:0] d;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  lab7_serial_sub #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from IDLE; operands are scrambled after the start edge.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                        input logic [4:0] exp, input string name);
    int n;
    int busy_n;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    n = 1;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    if (busy) busy_n++;
    check({name, " latency"}, n, 5);
    check({name, " busy cycles"}, busy_n, 5);
    check({name, " d"}, d, exp);
    tick();
    check({name, " done drop"}, done, 0);
    check({name, " idle"}, busy, 0);
  endtask

  initial begin
    int dones;
    int first_c;
    logic [4:0] dval;
    int dc[$];
    int exp_c[3];

    vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, exp: 5'h06};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, exp: 5'h1A};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, exp: 5'h1F};
    vecs[3] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, exp: 5'h0F};
    vecs[4] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, exp: 5'h00};
    vecs[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, exp: 5'h10};
    vecs[6] = '{a: 4'd15, b: 4'd15, bin: 1'b1, exp: 5'h1F};
    vecs[7] = '{a: 4'd8,  b: 4'd1,  bin: 1'b1, exp: 5'h06};

    // Reset with random inputs, start asserted
    rst_n = 1'b1; start = 1'b1;
    a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset d", d, 5'h00);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post-reset busy", busy, 0);
      check("post-reset done", done, 0);
      check("post-reset d", d, 5'h00);
    end

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));

    // Start pulse and operand changes during RUN must be ignored
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    dones = 0; first_c = 0; dval = '0;
    for (int c = 1; c <= 18; c++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin first_c = c; dval = d; end
      end
      if (c == 2) begin
        start = 1'b1; a = 4'd1; b = 4'd1;
      end else begin
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
      end
      tick();
    end
    check("midrun done count", dones, 1);
    check("midrun latency", first_c, 5);
    check("midrun d", dval, 5'h06);

    // start held high: one result every 6 cycles
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        dc.push_back(c);
        check("held d", d, 5'h03);
      end
      tick();
    end
    start = 1'b0;
    exp_c[0] = 5; exp_c[1] = 11; exp_c[2] = 17;
    check("held done count", dc.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("held done cycle %0d", i), (i < dc.size()) ? dc[i] : -1, exp_c[i]);
    repeat (8) tick();
    check("held drained", busy, 0);

    // Reset in the third RUN cycle
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-abort busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort d", d, 5'h00);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) dones++;
      tick();
    end
    check("no done after abort", dones, 0);
    run_op(4'd7, 4'd7, 1'b0, 5'h00, "after abort");

    // Exhaustive sweep against the reference model
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++)
          run_op(4'(x), 4'(y), 1'(z), 5'((x - y - z) & 'h1F), "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
